// File: rtl/ab_dec_pkg.sv
// Shared types for the AB step decoder: tracking states and
// the Gray code points of the forward AB sequence.
package ab_dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    FAULT
  } state_t;

  localparam logic [1:0] G0 = 2'b00;
  localparam logic [1:0] G1 = 2'b01;
  localparam logic [1:0] G2 = 2'b11;
  localparam logic [1:0] G3 = 2'b10;

  // Next code point in the forward direction.
  function automatic logic [1:0] gray_next(
    input logic [1:0] g
  );
    logic [1:0] n;
    unique case (g)
      G0:      n = G1;
      G1:      n = G2;
      G2:      n = G3;
      default: n = G0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ab_sync.sv
// Two-flop synchronizer for the AB pins, reset to 0; exists only
// when AB_SYNC_EN is defined. Ports: clk, rst, d[W], q[W].
`ifdef AB_SYNC_EN
module ab_sync #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '0;
      q <= '0;
    end else begin
      m <= d;
      q <= m;
    end
  end

endmodule
`endif

// File: rtl/ab_step_decoder.sv
// AB Gray-sequence step decoder: STEP/DIR/WRAP pulses, COUNT, ERR.
// In: CLK RST A B CLR. Out: STEP DIR COUNT WRAP ERR. AB_SYNC_EN adds sync.
module ab_step_decoder
  import ab_dec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A,
  input  logic             B,
  input  logic             CLR,
  output logic             STEP,
  output logic             DIR,
  output logic [WIDTH-1:0] COUNT,
  output logic             WRAP,
  output logic             ERR
);

  logic [1:0] ab_in;

`ifdef AB_SYNC_EN
  // Stay in IDLE until the reset-zeroed sync chain holds real pins.
  localparam logic [1:0] IDLE_LAST = 2'd2;

  ab_sync #(.W(2)) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   ({A, B}),
    .q   (ab_in)
  );
`else
  localparam logic [1:0] IDLE_LAST = 2'd0;

  assign ab_in = {A, B};
`endif

  state_t           state, state_n;
  logic [1:0]       s, prev, prev_n;
  logic [1:0]       icnt, icnt_n;
  logic [WIDTH-1:0] count_n;
  logic             dir_n, step_n;
  logic             wrap_n, err_n;
  logic             fwd, rev, jump;

  assign fwd  = (s == gray_next(prev));
  assign rev  = (prev == gray_next(s));
  assign jump = (s == ~prev);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      s     <= '0;
      prev  <= '0;
      icnt  <= '0;
      COUNT <= '0;
      DIR   <= 1'b0;
      STEP  <= 1'b0;
      WRAP  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= state_n;
      s     <= ab_in;
      prev  <= prev_n;
      icnt  <= icnt_n;
      COUNT <= count_n;
      DIR   <= dir_n;
      STEP  <= step_n;
      WRAP  <= wrap_n;
      ERR   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    prev_n  = s;
    icnt_n  = icnt;
    count_n = COUNT;
    dir_n   = DIR;
    step_n  = 1'b0;
    wrap_n  = 1'b0;
    err_n   = ERR;
    if (CLR) begin
      state_n = IDLE;
      icnt_n  = '0;
      count_n = '0;
      err_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // PREV takes the value S is loading now, so
          // nothing that moved before this point counts.
          prev_n = ab_in;
          if (icnt == IDLE_LAST) begin
            state_n = TRACK;
            icnt_n  = '0;
          end else begin
            icnt_n = icnt + 2'd1;
          end
        end
        TRACK: begin
          unique case (1'b1)
            fwd: begin
              count_n = COUNT + WIDTH'(1);
              dir_n   = 1'b1;
              step_n  = 1'b1;
              wrap_n  = &COUNT;
            end
            rev: begin
              count_n = COUNT - WIDTH'(1);
              dir_n   = 1'b0;
              step_n  = 1'b1;
              wrap_n  = ~|COUNT;
            end
            jump: begin
              err_n   = 1'b1;
              state_n = FAULT;
            end
            default: ;
          endcase
        end
        FAULT: ;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ab_step_decoder.sv
// Self-checking bench for ab_step_decoder: vector table with
// a latency scoreboard, then hand sequences for CLR and RST.
module tb_ab_step_decoder;

  localparam int W = 8;
`ifdef AB_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int NV = 23;

  typedef struct {
    logic [1:0]   ab;
    logic         step;
    logic         dir;
    logic [W-1:0] count;
    logic         wrap;
    logic         err;
    int           idx;
  } vec_t;

  logic         CLK = 1'b0;
  logic         RST, A, B, CLR;
  logic         STEP, DIR, WRAP, ERR;
  logic [W-1:0] COUNT;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl[NV];
  vec_t sbq[$];

  always #5 CLK = ~CLK;

  ab_step_decoder #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .A     (A),
    .B     (B),
    .CLR   (CLR),
    .STEP  (STEP),
    .DIR   (DIR),
    .COUNT (COUNT),
    .WRAP  (WRAP),
    .ERR   (ERR)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm,
                         input logic st, input logic dr,
                         input logic [W-1:0] ct,
                         input logic wr, input logic er);
    chk({nm, ".step"},  32'(STEP),  32'(st));
    chk({nm, ".dir"},   32'(DIR),   32'(dr));
    chk({nm, ".count"}, 32'(COUNT), 32'(ct));
    chk({nm, ".wrap"},  32'(WRAP),  32'(wr));
    chk({nm, ".err"},   32'(ERR),   32'(er));
  endtask

  task automatic row(input int i, input logic [1:0] ab,
                     input logic st, input logic dr,
                     input int ct, input logic wr,
                     input logic er);
    tbl[i].ab    = ab;
    tbl[i].step  = st;
    tbl[i].dir   = dr;
    tbl[i].count = W'(ct);
    tbl[i].wrap  = wr;
    tbl[i].err   = er;
    tbl[i].idx   = i;
  endtask

  task automatic pop_cmp();
    vec_t e;
    e = sbq.pop_front();
    chk_all($sformatf("row%0d", e.idx),
            e.step, e.dir, e.count, e.wrap, e.err);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    A   = 1'b0;
    B   = 1'b0;
    CLR = 1'b0;
    // forward, 2 cycles per code
    row(0,  2'b00, 0, 0, 0,   0, 0);
    row(1,  2'b00, 0, 0, 0,   0, 0);
    row(2,  2'b01, 1, 1, 1,   0, 0);
    row(3,  2'b01, 0, 1, 1,   0, 0);
    row(4,  2'b11, 1, 1, 2,   0, 0);
    row(5,  2'b11, 0, 1, 2,   0, 0);
    row(6,  2'b10, 1, 1, 3,   0, 0);
    row(7,  2'b10, 0, 1, 3,   0, 0);
    row(8,  2'b00, 1, 1, 4,   0, 0);
    row(9,  2'b00, 0, 1, 4,   0, 0);
    // reverse back to 0, 1 cycle per code
    row(10, 2'b10, 1, 0, 3,   0, 0);
    row(11, 2'b11, 1, 0, 2,   0, 0);
    row(12, 2'b01, 1, 0, 1,   0, 0);
    row(13, 2'b00, 1, 0, 0,   0, 0);
    row(14, 2'b00, 0, 0, 0,   0, 0);
    // wrap both ways
    row(15, 2'b10, 1, 0, 255, 1, 0);
    row(16, 2'b10, 0, 0, 255, 0, 0);
    row(17, 2'b00, 1, 1, 0,   1, 0);
    row(18, 2'b00, 0, 1, 0,   0, 0);
    // illegal jump, then everything ignored
    row(19, 2'b11, 0, 1, 0,   0, 1);
    row(20, 2'b10, 0, 1, 0,   0, 1);
    row(21, 2'b00, 0, 1, 0,   0, 1);
    row(22, 2'b01, 0, 1, 0,   0, 1);

    #2;
    chk_all("reset", 0, 0, 0, 0, 0);
    tick(2);
    RST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      if (sbq.size() >= LAT) pop_cmp();
      {A, B} = tbl[i].ab;
      sbq.push_back(tbl[i]);
    end
    while (sbq.size() > 0) begin
      @(negedge CLK);
      pop_cmp();
    end

    // CLR leaves FAULT; a move as CLR drops is not counted
    CLR = 1'b1;
    tick(1);
    chk_all("clr_fault", 0, 1, 0, 0, 0);
    CLR    = 1'b0;
    {A, B} = 2'b11;
    tick(LAT + 1);
    chk_all("clr_release", 0, 1, 0, 0, 0);
    {A, B} = 2'b10;
    tick(LAT);
    chk_all("after_clr_step", 1, 1, 1, 0, 0);
    tick(1);
    chk_all("step_pulse_end", 0, 1, 1, 0, 0);

    // CLR on the edge that would register a step
    {A, B} = 2'b00;
    tick(LAT - 1);
    CLR = 1'b1;
    tick(1);
    chk_all("clr_vs_step", 0, 1, 0, 0, 0);
    CLR = 1'b0;

    // 3 forward steps ending on AB=11, then RST pulse
    {A, B} = 2'b10;
    CLR    = 1'b1;
    tick(1);
    CLR = 1'b0;
    tick(LAT + 1);
    {A, B} = 2'b00;
    tick(2);
    {A, B} = 2'b01;
    tick(2);
    {A, B} = 2'b11;
    tick(LAT);
    chk_all("three_steps", 1, 1, 3, 0, 0);
    #1 RST = 1'b1;
    #1 chk_all("rst_async", 0, 0, 0, 0, 0);
    #2 RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk($sformatf("post_rst%0d.step", i),
          32'(STEP), 32'd0);
    end
    chk_all("post_rst", 0, 0, 0, 0, 0);
    {A, B} = 2'b01;
    tick(LAT);
    chk_all("post_rst_rev", 1, 0, 255, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ab_step_decoder.md
AB_STEP_DECODER -- requirements
Module: ab_step_decoder

Interface
REQ-001 Parameter: WIDTH, 8, bit width of the COUNT step counter.
REQ-002 Port: CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: RST  input  1  reset; asynchronous, active-high.
REQ-004 Port: A  input  1  upper state bit from the 2-bit Gray-sequence FSM.
REQ-005 Port: B  input  1  lower state bit from the 2-bit Gray-sequence FSM.
REQ-006 Port: CLR  input  1  synchronous clear of COUNT, ERR and the tracking state.
REQ-007 Port: STEP  output  1  one-cycle pulse per legal AB transition.
REQ-008 Port: DIR  output  1  direction of the last legal step; 1 = forward, 0 = reverse.
REQ-009 Port: COUNT  output  WIDTH  signed-agnostic step position; wraps modulo 2^WIDTH.
REQ-010 Port: WRAP  output  1  one-cycle pulse when COUNT wraps in either direction.
REQ-011 Port: ERR  output  1  sticky flag for an illegal transition (both bits changed).

Function
REQ-012 Forward sequence SHALL be AB = 00 -> 01 -> 11 -> 10 -> 00; the reverse sequence is the inverse.
REQ-013 The sampled value S SHALL be AB registered once; PREV SHALL hold the S value from the previous cycle.
REQ-014 States SHALL be IDLE, TRACK and FAULT.
REQ-015 IDLE: the first cycle after reset or CLR loads PREV from S without a step, then moves to TRACK.
REQ-016 TRACK, S == PREV: no output change except that STEP and WRAP return to 0.
REQ-017 TRACK, forward step: COUNT+1, DIR=1, STEP=1 for exactly one cycle.
REQ-018 TRACK, reverse step: COUNT-1, DIR=0, STEP=1 for exactly one cycle.
REQ-019 Latency: an AB change sampled at edge k SHALL produce STEP after edge k+1 (2 edges from pin to STEP).
REQ-020 Wrap: forward from 2^WIDTH-1 gives 0; reverse from 0 gives 2^WIDTH-1; either case SHALL pulse WRAP together with STEP.
REQ-021 TRACK, both bits changed: ERR=1, state moves to FAULT, COUNT and DIR hold, STEP=0.
REQ-022 FAULT: all AB activity SHALL be ignored; only CLR or RST exits this state.
REQ-023 CLR asserted: COUNT=0, ERR=0, STEP=0, WRAP=0, state moves to IDLE; CLR SHALL take priority over a simultaneous transition.
REQ-024 A step that occurs in the same cycle that CLR deasserts SHALL NOT be counted, because IDLE re-latches PREV.

Reset
REQ-025 RST high SHALL immediately force STEP=0, DIR=0, COUNT=0, WRAP=0, ERR=0, S=PREV=00 and state IDLE.
REQ-026 RST asserted mid-sequence SHALL discard any in-flight sample; there is no step on the first edge after release.

Configuration
REQ-027 Macro AB_SYNC_EN defined: A and B SHALL pass through a 2-flop synchronizer before S, raising pin-to-STEP latency to 4 edges.
REQ-028 Macro AB_SYNC_EN undefined: there SHALL be no synchronizer, and latency SHALL be as in REQ-019.

Structure
REQ-029 Package ab_dec_pkg SHALL hold the state enumeration (IDLE, TRACK, FAULT) and the four Gray code constants.
REQ-030 Sub-module ab_sync (2-flop synchronizer, reset to 0) SHALL be instantiated only under AB_SYNC_EN.

Verification
REQ-031 Reset, then AB 00->01->11->10->00, each held 2 cycles -> 4 STEP pulses, DIR=1, COUNT=4, ERR=0.
REQ-032 From COUNT=0, apply AB 00->10 -> STEP=1, DIR=0, COUNT=255, WRAP=1 (WIDTH=8).
REQ-033 AB 00->11 in TRACK -> ERR=1, COUNT unchanged; a further 11->10 is ignored; CLR for 1 cycle -> ERR=0, COUNT=0, state IDLE.
REQ-034 RST pulsed for 3 ns while AB=11 after 3 forward steps -> all outputs 0; no STEP on release.
REQ-035 CLR and a forward step in the same cycle -> COUNT=0, STEP=0.
REQ-036 With AB_SYNC_EN: AB changes at edge k -> STEP is high only in the cycle after edge k+3.
